max_reduce_seq: RTL and testbench
=================================

// Module: max_reduce_seq
// PURPOSE
// - Sequences one shared WIDTH-bit max comparator over a streamed frame of up to COUNT
//   elements. Returns the frame maximum, the index of its first occurrence and the beat count.
// - Sits between a sample stream and downstream peak/threshold logic.
// - Comparison uses the package max() rule: a new element replaces the running max only if
//   strictly greater, so ties keep the earlier element.
// PARAMETERS
// - WIDTH   32  element width in bits
// - COUNT   8   max elements per frame (>=1)
// - SIGNED  1   1: two's-complement compare; 0: unsigned compare
// - IW = (COUNT>1) ? $clog2(COUNT) : 1    (derived) index width
// - CW = $clog2(COUNT+1)                  (derived) count width
// PORTS
// - clk          in   1      clock; all logic on rising edge
// - resetn       in   1      synchronous, active-low reset
// - s_data       in   WIDTH  input element
// - s_valid      in   1      s_data valid
// - s_last       in   1      marks final element of the frame
// - s_ready      out  1      block accepts an element this cycle
// - m_max        out  WIDTH  frame maximum
// - m_index      out  IW     position (0-based) of first occurrence of m_max
// - m_count      out  CW     elements in frame (1..COUNT)
// - m_truncated  out  1      frame closed by reaching COUNT with s_last low
// - m_valid      out  1      result valid
// - m_ready      in   1      downstream accepts result
// BEHAVIOUR
// - Beat accepted iff s_valid & s_ready. Result transferred iff m_valid & m_ready.
// - Reset (resetn=0 at clk edge): state=IDLE; s_ready=0 during reset, 1 from the first
//   cycle after release; m_valid=0; m_max=0, m_index=0, m_count=0, m_truncated=0.
// - Reset mid-frame or with m_valid high discards all partial and pending data.
// - FSM, 3 states:
//   - IDLE: s_ready=1, m_valid=0.
//     - Accepted beat: max<=s_data, index<=0, cnt<=1.
//     - Close condition (s_last | COUNT==1) -> DONE; else -> ACCUM.
//   - ACCUM: s_ready=1, m_valid=0.
//     - Accepted beat: if s_data > max (per SIGNED) then max<=s_data, index<=cnt.
//       cnt<=cnt+1.
//     - If s_last | cnt+1==COUNT -> DONE, else stay in ACCUM.
//   - DONE: s_ready=0, m_valid=1, outputs held stable.
//     - m_ready=1 -> IDLE. No new beat is accepted in the same cycle.
// - m_truncated = (final cnt==COUNT) & ~s_last on the closing beat; registered with the result.
// - Latency: m_valid rises the cycle after the closing beat is accepted.
// - Throughput: one frame per (n+1) cycles minimum, where n = beats in the frame.
// - s_valid low during ACCUM: hold state, no counter change; gaps are allowed.
// - s_data and s_last are ignored when the beat is not accepted.
// - m_* outputs are registered; they change only on reset or on entry to DONE.
// - Counter never exceeds COUNT.
// - The next beat after a truncated close starts a new frame at index 0.
// TESTING
// - Reset: hold resetn=0 3 cycles -> s_ready=0, m_valid=0, m_* all 0; s_ready=1 the cycle after release.
// - WIDTH=8, SIGNED=1, frame {3,-5,7,7,2}, last on 5th -> m_max=7, m_index=2, m_count=5, m_truncated=0.
// - SIGNED=0, same bytes (0xFB=251) -> m_max=251, m_index=1.
// - COUNT=8, 10 beats {0..9} with no s_last:
//   - frame 1: m_max=7, m_index=7, m_count=8, m_truncated=1.
//   - frame 2: beats 8,9 with s_last on 9 -> m_max=9, m_index=1, m_count=2.
// - Backpressure: m_ready=0 for 4 cycles in DONE -> s_ready=0 and m_* stable throughout;
//   random s_valid gaps in ACCUM -> result unchanged.
// - Mid-frame reset after 3 beats, then frame {1}, s_last -> m_max=1, m_count=1, no stale data.
//   COUNT=1: every beat closes its own frame.

Source files
------------

// File: rtl/max_reduce_seq.sv
// max_reduce_seq: streams up to COUNT elements through one shared comparator and
// returns the frame maximum, the index of its first occurrence, the beat count and
// a flag telling whether the frame was closed by hitting COUNT instead of s_last.
module max_reduce_seq #(
  parameter  int WIDTH  = 32,
  parameter  int COUNT  = 8,
  parameter  int SIGNED = 1,
  localparam int IW     = (COUNT > 1) ? $clog2(COUNT) : 1,
  localparam int CW     = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_max,
  output logic [IW-1:0]    m_index,
  output logic [CW-1:0]    m_count,
  output logic             m_truncated,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam logic [CW-1:0] CNT_MAX = CW'(COUNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_e;

  state_e state_q, state_d;

  // running accumulators for the frame in flight
  logic [WIDTH-1:0] max_q, max_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // result registers; only loaded on the closing beat so they stay stable in DONE
  logic [WIDTH-1:0] m_max_q, m_max_d;
  logic [IW-1:0]    m_index_q, m_index_d;
  logic [CW-1:0]    m_count_q, m_count_d;
  logic             m_trunc_q, m_trunc_d;

  logic             accept;
  logic             gt;
  logic             close;
  logic [WIDTH-1:0] beat_max;
  logic [IW-1:0]    beat_idx;
  logic [CW-1:0]    beat_cnt;

  // shared comparator: strictly greater, so ties keep the earlier element
  always_comb begin
    gt = 1'b0;
    if (SIGNED != 0) gt = $signed(s_data) > $signed(max_q);
    else             gt = s_data > max_q;
  end

  // fold the current beat into the running max; the first beat of a frame always wins
  always_comb begin
    accept   = s_valid & s_ready;
    beat_max = max_q;
    beat_idx = idx_q;
    beat_cnt = cnt_q + CNT_ONE;
    if (state_q == IDLE) begin
      beat_max = s_data;
      beat_idx = '0;
      beat_cnt = CNT_ONE;
    end else if (gt) begin
      beat_max = s_data;
      beat_idx = cnt_q[IW-1:0];
    end
    close = s_last | (beat_cnt == CNT_MAX);
  end

  // next-state for datapath and result registers
  always_comb begin
    max_d     = max_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    m_max_d   = m_max_q;
    m_index_d = m_index_q;
    m_count_d = m_count_q;
    m_trunc_d = m_trunc_q;
    if (accept) begin
      max_d = beat_max;
      idx_d = beat_idx;
      cnt_d = beat_cnt;
      if (close) begin
        m_max_d   = beat_max;
        m_index_d = beat_idx;
        m_count_d = beat_cnt;
        m_trunc_d = (beat_cnt == CNT_MAX) & ~s_last;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state: a closing beat moves to DONE, a taken result returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = close ? DONE : ACCUM;
      DONE:        if (m_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // FSM outputs; ready is held low while reset is asserted
  always_comb begin
    s_ready = resetn & (state_q != DONE);
    m_valid = (state_q == DONE);
  end

  // datapath and result registers; reset drops any partial or pending frame
  always_ff @(posedge clk) begin
    if (!resetn) begin
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      m_max_q   <= '0;
      m_index_q <= '0;
      m_count_q <= '0;
      m_trunc_q <= 1'b0;
    end else begin
      max_q     <= max_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      m_max_q   <= m_max_d;
      m_index_q <= m_index_d;
      m_count_q <= m_count_d;
      m_trunc_q <= m_trunc_d;
    end
  end

  assign m_max       = m_max_q;
  assign m_index     = m_index_q;
  assign m_count     = m_count_q;
  assign m_truncated = m_trunc_q;

endmodule

// File: tb/tb_max_reduce_seq.sv
// Directed bench: one signed and one unsigned 8-bit/COUNT=8 instance share a stimulus
// stream, and a COUNT=1 instance gets its own stream.
module tb_max_reduce_seq;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // shared stream for signed (s_) and unsigned (u_) instances
  logic [7:0] a_dat = '0;
  logic       a_val = 1'b0, a_last = 1'b0, a_mrdy = 1'b0;
  logic       s_rdy, s_mv, s_tr, u_rdy, u_mv, u_tr;
  logic [7:0] s_mx, u_mx;
  logic [2:0] s_ix, u_ix;
  logic [3:0] s_ct, u_ct;

  // COUNT=1 instance
  logic [7:0] c_dat = '0;
  logic       c_val = 1'b0, c_last = 1'b0, c_mrdy = 1'b0;
  logic       c_rdy, c_mv, c_tr;
  logic [7:0] c_mx;
  logic [0:0] c_ix, c_ct;

  max_reduce_seq #(.WIDTH(8), .COUNT(8), .SIGNED(1)) u_sgn (
    .clk(clk), .resetn(resetn), .s_data(a_dat), .s_valid(a_val), .s_last(a_last),
    .s_ready(s_rdy), .m_max(s_mx), .m_index(s_ix), .m_count(s_ct), .m_truncated(s_tr),
    .m_valid(s_mv), .m_ready(a_mrdy));

  max_reduce_seq #(.WIDTH(8), .COUNT(8), .SIGNED(0)) u_uns (
    .clk(clk), .resetn(resetn), .s_data(a_dat), .s_valid(a_val), .s_last(a_last),
    .s_ready(u_rdy), .m_max(u_mx), .m_index(u_ix), .m_count(u_ct), .m_truncated(u_tr),
    .m_valid(u_mv), .m_ready(a_mrdy));

  max_reduce_seq #(.WIDTH(8), .COUNT(1), .SIGNED(1)) u_one (
    .clk(clk), .resetn(resetn), .s_data(c_dat), .s_valid(c_val), .s_last(c_last),
    .s_ready(c_rdy), .m_max(c_mx), .m_index(c_ix), .m_count(c_ct), .m_truncated(c_tr),
    .m_valid(c_mv), .m_ready(c_mrdy));

  // present one beat on the shared stream after 'gap' idle cycles (s_last/s_data junk
  // while s_valid is low); returns on the negedge after the accepting edge
  task automatic send(input logic [7:0] d, input logic last, input int gap = 0);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      a_val = 1'b0; a_last = 1'b1; a_dat = 8'($urandom);
    end
    @(negedge clk);
    while (!s_rdy && n < 20) begin @(negedge clk); n++; end
    if (!s_rdy) begin
      checks++; failures++;
      $display("FAIL send_timeout s_ready=%0b required=1", s_rdy);
    end
    a_val = 1'b1; a_dat = d; a_last = last;
    @(negedge clk);
    a_val = 1'b0; a_last = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (!c_rdy && n < 20) begin @(negedge clk); n++; end
    if (!c_rdy) begin
      checks++; failures++;
      $display("FAIL send_c_timeout c_ready=%0b required=1", c_rdy);
    end
    c_val = 1'b1; c_dat = d; c_last = last;
    @(negedge clk);
    c_val = 1'b0; c_last = 1'b0;
  endtask

  // hand the pending result downstream for one cycle; block must come back ready
  task automatic take_result;
    a_mrdy = 1'b1;
    @(negedge clk);
    a_mrdy = 1'b0;
    checks++;
    if (s_mv !== 1'b0 || s_rdy !== 1'b1) begin
      failures++;
      $display("FAIL take_result m_valid=%0b s_ready=%0b required 0/1", s_mv, s_rdy);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_rdy, s_mv, s_mx, s_ix, s_ct, s_tr} !== '0) begin
      failures++;
      $display("FAIL reset_sgn rdy=%0b mv=%0b max=%0d idx=%0d cnt=%0d tr=%0b required all 0",
               s_rdy, s_mv, s_mx, s_ix, s_ct, s_tr);
    end
    checks++;
    if ({c_rdy, c_mv, c_mx, c_ix, c_ct, c_tr} !== '0) begin
      failures++;
      $display("FAIL reset_one rdy=%0b mv=%0b max=%0d cnt=%0d required all 0", c_rdy, c_mv, c_mx, c_ct);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_rdy !== 1'b1 || c_rdy !== 1'b1 || s_mv !== 1'b0) begin
      failures++;
      $display("FAIL reset_release s_ready=%0b c_ready=%0b m_valid=%0b required 1/1/0", s_rdy, c_rdy, s_mv);
    end
  endtask

  task automatic test_signed_unsigned;
    send(8'd3, 1'b0); send(8'hFB, 1'b0); send(8'd7, 1'b0); send(8'd7, 1'b0); send(8'd2, 1'b1);
    checks++;
    if ({s_mv, s_rdy, s_mx, s_ix, s_ct, s_tr} !== {1'b1, 1'b0, 8'd7, 3'd2, 4'd5, 1'b0}) begin
      failures++;
      $display("FAIL signed_frame mv=%0b rdy=%0b max=%0d idx=%0d cnt=%0d tr=%0b required 1 0 7 2 5 0",
               s_mv, s_rdy, s_mx, s_ix, s_ct, s_tr);
    end
    checks++;
    if ({u_mv, u_mx, u_ix, u_ct, u_tr} !== {1'b1, 8'd251, 3'd1, 4'd5, 1'b0}) begin
      failures++;
      $display("FAIL unsigned_frame mv=%0b max=%0d idx=%0d cnt=%0d tr=%0b required 1 251 1 5 0",
               u_mv, u_mx, u_ix, u_ct, u_tr);
    end
    take_result();
  endtask

  task automatic test_truncate;
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 1'b0);
      if (i < 7) begin
        checks++;
        if (s_mv !== 1'b0) begin
          failures++;
          $display("FAIL trunc_early beat=%0d m_valid=%0b required 0", i, s_mv);
        end
      end
    end
    checks++;
    if ({s_mv, s_mx, s_ix, s_ct, s_tr} !== {1'b1, 8'd7, 3'd7, 4'd8, 1'b1}) begin
      failures++;
      $display("FAIL trunc_frame1 mv=%0b max=%0d idx=%0d cnt=%0d tr=%0b required 1 7 7 8 1",
               s_mv, s_mx, s_ix, s_ct, s_tr);
    end
    take_result();
    send(8'd8, 1'b0); send(8'd9, 1'b1);
    checks++;
    if ({s_mv, s_mx, s_ix, s_ct, s_tr} !== {1'b1, 8'd9, 3'd1, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL trunc_frame2 mv=%0b max=%0d idx=%0d cnt=%0d tr=%0b required 1 9 1 2 0",
               s_mv, s_mx, s_ix, s_ct, s_tr);
    end
    take_result();
  endtask

  task automatic test_backpressure;
    send(8'd5, 1'b0); send(8'd9, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b1);
    // stall downstream while upstream keeps offering a beat that must not be taken
    a_val = 1'b1; a_dat = 8'd200; a_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({s_rdy, s_mv, s_mx, s_ix, s_ct, s_tr} !== {1'b0, 1'b1, 8'd9, 3'd1, 4'd4, 1'b0}) begin
        failures++;
        $display("FAIL backpressure cyc=%0d rdy=%0b mv=%0b max=%0d idx=%0d cnt=%0d required 0 1 9 1 4",
                 k, s_rdy, s_mv, s_mx, s_ix, s_ct);
      end
    end
    // release edge: beat still offered but DONE must not accept it
    a_mrdy = 1'b1;
    @(negedge clk);
    a_mrdy = 1'b0; a_val = 1'b0; a_last = 1'b0;
    send(8'd1, 1'b1);
    checks++;
    if ({s_mv, s_mx, s_ct} !== {1'b1, 8'd1, 4'd1}) begin
      failures++;
      $display("FAIL done_no_accept mv=%0b max=%0d cnt=%0d required 1 1 1", s_mv, s_mx, s_ct);
    end
    take_result();
    // gaps inside the frame with junk s_last/s_data
    send(8'hFE, 1'b0, 0); send(8'd4, 1'b0, 1); send(8'd4, 1'b0, 3); send(8'd3, 1'b1, 2);
    checks++;
    if ({s_mv, s_mx, s_ix, s_ct, s_tr} !== {1'b1, 8'd4, 3'd1, 4'd4, 1'b0}) begin
      failures++;
      $display("FAIL gaps_signed mv=%0b max=%0d idx=%0d cnt=%0d tr=%0b required 1 4 1 4 0",
               s_mv, s_mx, s_ix, s_ct, s_tr);
    end
    checks++;
    if ({u_mx, u_ix, u_ct} !== {8'd254, 3'd0, 4'd4}) begin
      failures++;
      $display("FAIL gaps_unsigned max=%0d idx=%0d cnt=%0d required 254 0 4", u_mx, u_ix, u_ct);
    end
    take_result();
  endtask

  task automatic test_midframe_reset;
    send(8'd50, 1'b0); send(8'd60, 1'b0); send(8'd70, 1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_rdy, s_mv, s_mx, s_ct} !== '0) begin
      failures++;
      $display("FAIL midreset rdy=%0b mv=%0b max=%0d cnt=%0d required all 0", s_rdy, s_mv, s_mx, s_ct);
    end
    resetn = 1'b1;
    send(8'd1, 1'b1);
    checks++;
    if ({s_mv, s_mx, s_ix, s_ct, s_tr} !== {1'b1, 8'd1, 3'd0, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL after_reset mv=%0b max=%0d idx=%0d cnt=%0d tr=%0b required 1 1 0 1 0",
               s_mv, s_mx, s_ix, s_ct, s_tr);
    end
    take_result();
  endtask

  task automatic test_count1;
    send_c(8'd5, 1'b0);
    checks++;
    if ({c_mv, c_rdy, c_mx, c_ix, c_ct, c_tr} !== {1'b1, 1'b0, 8'd5, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL count1_trunc mv=%0b rdy=%0b max=%0d cnt=%0d tr=%0b required 1 0 5 1 1",
               c_mv, c_rdy, c_mx, c_ct, c_tr);
    end
    c_mrdy = 1'b1; @(negedge clk); c_mrdy = 1'b0;
    send_c(8'hF0, 1'b1);
    checks++;
    if ({c_mv, c_mx, c_ix, c_ct, c_tr} !== {1'b1, 8'hF0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL count1_last mv=%0b max=%0d cnt=%0d tr=%0b required 1 240 1 0",
               c_mv, c_mx, c_ct, c_tr);
    end
    c_mrdy = 1'b1; @(negedge clk); c_mrdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_signed_unsigned();
    test_truncate();
    test_backpressure();
    test_midframe_reset();
    test_count1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
